// File: rtl/instruction_prefetch_queue.sv
// Instruction prefetch queue: one-outstanding-request fetcher feeding a DEPTH-entry FIFO toward IF/ID.
// Optional macro PREFETCH_BYPASS_EN forwards an ack straight to fetch_* when the queue is empty.
module instruction_prefetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [63:0] PC_RESET = 64'h0
) (
   input  logic                     CLOCK,
   input  logic                     RESET,
   input  logic                     redirect_valid,
   input  logic [63:0]              redirect_pc,
   output logic                     imem_req,
   output logic [63:0]              imem_addr,
   input  logic                     imem_ack,
   input  logic [31:0]              imem_data,
   output logic                     fetch_valid,
   output logic [63:0]              fetch_pc,
   output logic [31:0]              fetch_instr,
   input  logic                     fetch_ready,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, DROP} stateType;

   stateType         state, stateNext;
   logic [63:0]      nextPc, imemAddrReg;
   logic [63:0]      pcMem    [DEPTH];
   logic [31:0]      instrMem [DEPTH];
   logic [PTR_W-1:0] headPtr, tailPtr;
   logic [PTR_W:0]   count;
   logic             queueEmpty, queueFull, ackKeep, bypassTake, bypassPop;
   logic             doPush, doPop, issueReq;
   logic             unusedPcLsbs;

   assign unusedPcLsbs = ^redirect_pc[1:0];

   assign queueEmpty = (count == '0);
   assign queueFull  = (count == FULL_CNT);
   assign ackKeep    = (state == WAIT) && imem_ack && !redirect_valid;

`ifdef PREFETCH_BYPASS_EN
   assign bypassTake = ackKeep && queueEmpty;
`else
   assign bypassTake = 1'b0;
`endif
   // A bypassed word that the consumer takes immediately never enters the queue.
   assign bypassPop = bypassTake && fetch_ready;
   assign doPush    = ackKeep && !bypassPop;
   assign doPop     = !queueEmpty && fetch_ready && !redirect_valid;

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: if (!redirect_valid && !queueFull) stateNext = WAIT;
         WAIT: begin
            if (imem_ack)            stateNext = IDLE;
            else if (redirect_valid) stateNext = DROP;
         end
         DROP: if (imem_ack) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   assign issueReq = (state == IDLE) && (stateNext == WAIT);

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state       <= IDLE;
         imemAddrReg <= '0;
         nextPc      <= PC_RESET;
         headPtr     <= '0;
         tailPtr     <= '0;
         count       <= '0;
      end else begin
         state <= stateNext;
         if (issueReq) imemAddrReg <= nextPc;
         if (redirect_valid)  nextPc <= {redirect_pc[63:2], 2'b00};
         else if (ackKeep)    nextPc <= imemAddrReg + 64'd4;
         // Redirect flushes the queue and overrides any same-cycle push or pop.
         if (redirect_valid) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
         end else begin
            if (doPush) tailPtr <= tailPtr + 1'b1;
            if (doPop)  headPtr <= headPtr + 1'b1;
            if (doPush && !doPop)      count <= count + 1'b1;
            else if (!doPush && doPop) count <= count - 1'b1;
         end
      end
   end

   always_ff @(posedge CLOCK) begin
      if (doPush) begin
         pcMem[tailPtr]    <= imemAddrReg;
         instrMem[tailPtr] <= imem_data;
      end
   end

   always_comb begin
      fetch_valid = !queueEmpty || bypassTake;
      fetch_pc    = '0;
      fetch_instr = '0;
      if (!queueEmpty) begin
         fetch_pc    = pcMem[headPtr];
         fetch_instr = instrMem[headPtr];
      end
`ifdef PREFETCH_BYPASS_EN
      else if (bypassTake) begin
         fetch_pc    = imemAddrReg;
         fetch_instr = imem_data;
      end
`endif
   end

   assign imem_req  = (state != IDLE);
   assign imem_addr = imemAddrReg;
   assign occupancy = count;

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Directed self-checking bench for instruction_prefetch_queue (DEPTH=4, PC_RESET=0).
module tb_instruction_prefetch_queue;

   logic        CLOCK = 1'b0;
   logic        RESET;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic        fetch_valid;
   logic [63:0] fetch_pc;
   logic [31:0] fetch_instr;
   logic        fetch_ready;
   logic [2:0]  occupancy;

   int checks   = 0;
   int failures = 0;
   logic memAuto = 1'b0;
   int   memLat  = 0;
   int   memCnt  = 0;

   instruction_prefetch_queue #(.DEPTH(4), .PC_RESET(64'h0)) dut (
      .CLOCK(CLOCK), .RESET(RESET),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_data(imem_data),
      .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
      .fetch_ready(fetch_ready), .occupancy(occupancy)
   );

   always #5 CLOCK = ~CLOCK;

   function automatic logic [31:0] wordFor(input logic [63:0] a);
      return a[31:0] ^ 32'h5A5A_0000;
   endfunction

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic waitReq(input string tag);
      int n = 0;
      while (!imem_req && n < 50) begin
         tick();
         n++;
      end
      checkVal(tag, 64'(imem_req), 64'd1);
   endtask

   task automatic applyReset();
      memAuto = 1'b0;
      imem_ack = 1'b0;
      redirect_valid = 1'b0;
      fetch_ready = 1'b0;
      RESET = 1'b1;
      tick();
      tick();
      RESET = 1'b0;
   endtask

   // Memory model: acks memLat cycles after the request is first seen.
   always @(negedge CLOCK) begin
      if (memAuto) begin
         imem_ack = 1'b0;
         if (imem_req) begin
            if (memCnt >= memLat) begin
               imem_ack  = 1'b1;
               imem_data = wordFor(imem_addr);
               memCnt    = 0;
            end else memCnt++;
         end else memCnt = 0;
      end else memCnt = 0;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int got;
      int reqSeen;
      logic [63:0] firstAddr;
      logic found;
      RESET = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
      imem_ack = 1'b0; imem_data = '0; fetch_ready = 1'b0;
      tick();
      tick();
      checkVal("rst_occ",   64'(occupancy),   64'd0);
      checkVal("rst_req",   64'(imem_req),    64'd0);
      checkVal("rst_addr",  imem_addr,        64'd0);
      checkVal("rst_valid", 64'(fetch_valid), 64'd0);
      checkVal("rst_pc",    fetch_pc,         64'd0);
      checkVal("rst_instr", 64'(fetch_instr), 64'd0);
      RESET = 1'b0;

      // In-order stream 0,4,8,12 with ack one cycle after each request.
      memLat = 1; memAuto = 1'b1; fetch_ready = 1'b1;
      got = 0; n = 0;
      while (got < 4 && n < 80) begin
         @(negedge CLOCK);
         #1;
         if (fetch_valid) begin
            checkVal($sformatf("seq_pc%0d", got), fetch_pc, 64'(got * 4));
            checkVal($sformatf("seq_instr%0d", got), 64'(fetch_instr), 64'(wordFor(64'(got * 4))));
            got++;
         end
         n++;
      end
      checkVal("seq_count", 64'(got), 64'd4);

      // Fill to DEPTH with the consumer stalled, then release a single slot.
      applyReset();
      memLat = 0; memAuto = 1'b1;
      n = 0;
      while (occupancy != 3'd4 && n < 60) begin tick(); n++; end
      checkVal("full_occ", 64'(occupancy), 64'd4);
      reqSeen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (imem_req) reqSeen++;
      end
      checkVal("full_noreq", 64'(reqSeen), 64'd0);
      checkVal("full_head", fetch_pc, 64'h0);
      fetch_ready = 1'b1;
      tick();
      fetch_ready = 1'b0;
      checkVal("pop_occ", 64'(occupancy), 64'd3);
      reqSeen = 0; firstAddr = '1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (imem_req) begin
            if (reqSeen == 0) firstAddr = imem_addr;
            reqSeen++;
         end
      end
      checkVal("refill_reqs", 64'(reqSeen), 64'd1);
      checkVal("refill_addr", firstAddr, 64'h10);
      checkVal("refill_occ", 64'(occupancy), 64'd4);

      // Redirect while waiting on 0x8; the late ack must be dropped.
      applyReset();
      memLat = 1; memAuto = 1'b1; fetch_ready = 1'b1;
      n = 0; found = 1'b0;
      while (!found && n < 60) begin
         tick();
         if (imem_req && imem_addr == 64'h8) found = 1'b1;
         n++;
      end
      memAuto = 1'b0; imem_ack = 1'b0;
      checkVal("rd_found", 64'(found), 64'd1);
      redirect_valid = 1'b1; redirect_pc = 64'h1003;
      tick();
      redirect_valid = 1'b0;
      checkVal("drop_req",  64'(imem_req), 64'd1);
      checkVal("drop_addr", imem_addr,     64'h8);
      tick();
      tick();
      imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
      tick();
      imem_ack = 1'b0;
      checkVal("drop_occ",   64'(occupancy),   64'd0);
      checkVal("drop_valid", 64'(fetch_valid), 64'd0);
      checkVal("drop_idle",  64'(imem_req),    64'd0);
      memAuto = 1'b1;
      waitReq("rd_req");
      checkVal("rd_addr", imem_addr, 64'h1000);
      n = 0;
      while (!fetch_valid && n < 20) begin @(negedge CLOCK); #1; n++; end
      checkVal("rd_pc",    fetch_pc,         64'h1000);
      checkVal("rd_instr", 64'(fetch_instr), 64'(wordFor(64'h1000)));

      // Redirect coinciding with ack and pop on a two-entry queue.
      applyReset();
      for (int i = 0; i < 2; i++) begin
         waitReq($sformatf("fill_req%0d", i));
         imem_ack = 1'b1; imem_data = wordFor(imem_addr);
         tick();
         imem_ack = 1'b0;
      end
      waitReq("coin_req");
      checkVal("coin_occ2", 64'(occupancy), 64'd2);
      checkVal("coin_addr", imem_addr,      64'h8);
      imem_ack = 1'b1; imem_data = wordFor(imem_addr);
      redirect_valid = 1'b1; redirect_pc = 64'h2000; fetch_ready = 1'b1;
      tick();
      imem_ack = 1'b0; redirect_valid = 1'b0; fetch_ready = 1'b0;
      checkVal("coin_occ0",  64'(occupancy),   64'd0);
      checkVal("coin_valid", 64'(fetch_valid), 64'd0);
      checkVal("coin_idle",  64'(imem_req),    64'd0);
      waitReq("coin_req2");
      checkVal("coin_addr2", imem_addr, 64'h2000);

      // Redirect in the ack cycle with an empty queue: nothing forwarded.
      imem_ack = 1'b1; imem_data = wordFor(imem_addr);
      redirect_valid = 1'b1; redirect_pc = 64'h3000; fetch_ready = 1'b1;
      #1;
      checkVal("rdack_valid", 64'(fetch_valid), 64'd0);
      tick();
      imem_ack = 1'b0; redirect_valid = 1'b0; fetch_ready = 1'b0;
      checkVal("rdack_occ", 64'(occupancy), 64'd0);
      waitReq("rdack_req");
      checkVal("rdack_addr", imem_addr, 64'h3000);

      // Reset during WAIT, stale ack afterwards, then first fetch from PC_RESET.
      RESET = 1'b1;
      tick();
      tick();
      RESET = 1'b0;
      checkVal("wrst_req",  64'(imem_req), 64'd0);
      checkVal("wrst_addr", imem_addr,     64'd0);
      imem_ack = 1'b1; imem_data = 32'hBADB_AD00; fetch_ready = 1'b1;
      #1;
      checkVal("stale_valid", 64'(fetch_valid), 64'd0);
      tick();
      imem_ack = 1'b0;
      checkVal("stale_occ",  64'(occupancy), 64'd0);
      checkVal("stale_req",  64'(imem_req),  64'd1);
      checkVal("stale_addr", imem_addr,      64'd0);
      imem_ack = 1'b1; imem_data = wordFor(64'h0);
      #1;
`ifdef PREFETCH_BYPASS_EN
      checkVal("byp_valid", 64'(fetch_valid), 64'd1);
      checkVal("byp_pc",    fetch_pc,         64'h0);
      checkVal("byp_instr", 64'(fetch_instr), 64'(wordFor(64'h0)));
      tick();
      imem_ack = 1'b0;
      checkVal("byp_occ",    64'(occupancy),   64'd0);
      checkVal("byp_after",  64'(fetch_valid), 64'd0);
`else
      checkVal("nobyp_valid0", 64'(fetch_valid), 64'd0);
      tick();
      imem_ack = 1'b0;
      checkVal("nobyp_valid1", 64'(fetch_valid), 64'd1);
      checkVal("nobyp_pc",     fetch_pc,         64'h0);
      checkVal("nobyp_instr",  64'(fetch_instr), 64'(wordFor(64'h0)));
      checkVal("nobyp_occ",    64'(occupancy),   64'd1);
`endif
      fetch_ready = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instruction_prefetch_queue.md
INSTRUCTION_PREFETCH_QUEUE -- requirements
Module: instruction_prefetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries (power of two, 2..16).
REQ-002 Parameter PC_RESET, default 64'h0, fetch address loaded on reset.
REQ-003 CLOCK  input  1  sole clock; all state updates on rising edge.
REQ-004 RESET  input  1  reset, synchronous and active-high.
REQ-005 redirect_valid  input  1  branch redirect from the pipeline; flushes the queue.
REQ-006 redirect_pc  input  64  new fetch address; bits [1:0] ignored and forced to 2'b00.
REQ-007 imem_req  output  1  instruction-memory request strobe.
REQ-008 imem_addr  output  64  instruction-memory word address.
REQ-009 imem_ack  input  1  memory response strobe; imem_data valid this cycle.
REQ-010 imem_data  input  32  fetched instruction word.
REQ-011 fetch_valid  output  1  queue head valid, toward the IF/ID register.
REQ-012 fetch_pc  output  64  PC of the queue head.
REQ-013 fetch_instr  output  32  instruction at the queue head.
REQ-014 fetch_ready  input  1  IF/ID consumer accepts the head this cycle.
REQ-015 occupancy  output  $clog2(DEPTH)+1  current entry count.

Function
REQ-016 FSM states: IDLE (no request outstanding), WAIT (request outstanding, response kept), DROP (request outstanding, response discarded).
REQ-017 imem_req SHALL be 1 exactly in WAIT and DROP, registered; imem_addr SHALL hold stable from req rise until the ack cycle.
REQ-018 IDLE->WAIT when occupancy < DEPTH and no redirect; imem_addr := next_pc.
REQ-019 WAIT with imem_ack: push {imem_addr, imem_data}, next_pc := imem_addr+4 (mod 2^64), go IDLE.
REQ-020 A request is issued only with a free slot, so a push never overflows; push and pop in the same cycle leave occupancy unchanged.
REQ-021 Pop occurs when fetch_valid and fetch_ready; head/tail pointers wrap modulo DEPTH.
REQ-022 fetch_valid = (occupancy != 0); fetch_pc/fetch_instr SHALL be 0 when empty.
REQ-023 Redirect: queue emptied, any same-cycle pop/push suppressed, next_pc := {redirect_pc[63:2],2'b00}; in effect next cycle.
REQ-024 Redirect in WAIT without ack -> DROP; redirect in WAIT with same-cycle ack -> data discarded, go IDLE.
REQ-025 DROP: on imem_ack discard data, go IDLE; a further redirect in DROP only updates next_pc.
REQ-026 Latency (macro absent): instruction visible on fetch_valid the cycle after its ack; steady-state throughput one instruction per two cycles per request.

Reset
REQ-027 RESET SHALL take priority over all inputs, including redirect and ack.
REQ-028 After reset: state IDLE, queue empty, occupancy 0, imem_req 0, imem_addr 0, fetch_valid 0, fetch_pc 0, fetch_instr 0, next_pc PC_RESET.
REQ-029 Reset during WAIT/DROP abandons the request; the first ack after reset, if not preceded by a new request, SHALL be ignored.

Configuration
REQ-030 Macro PREFETCH_BYPASS_EN: when defined, an ack in WAIT with the queue empty drives fetch_valid=1, fetch_pc=imem_addr, fetch_instr=imem_data in the same cycle; if fetch_ready is also 1 the word is not written to the queue.
REQ-031 Without PREFETCH_BYPASS_EN: no combinational path from imem_* to fetch_*; behaviour per REQ-026.
REQ-032 Redirect in the ack cycle SHALL suppress the bypass (fetch_valid 0) in both builds.

Verification
REQ-033 Reset, PC_RESET=0, ack one cycle after each req, fetch_ready=1 -> fetch_pc 0,4,8,12 in order with matching imem_data.
REQ-034 fetch_ready=0, DEPTH=4, immediate acks -> occupancy reaches 4, imem_req stays 0; one pop -> exactly one new request at next PC 0x10.
REQ-035 Redirect to 0x1003 while WAIT at 0x8, ack 3 cycles later -> word for 0x8 discarded, next request addr 0x1000, first fetch_pc 0x1000.
REQ-036 Redirect coincident with ack and with a pop on a 2-entry queue -> occupancy 0 next cycle, no word pushed, next request 0x(redirect).
REQ-037 RESET asserted in WAIT, stale ack 2 cycles later -> ignored; first fetch_pc after reset = PC_RESET.
REQ-038 PREFETCH_BYPASS_EN defined, empty queue, ack with fetch_ready=1 -> fetch_valid=1 in ack cycle, occupancy stays 0; undefined -> fetch_valid rises one cycle later.
